ahb_lite_arb2m: RTL and testbench

- Registered AHB-Lite arbiter that shares one slave port between the two EL2 masters (IFU = M1, LSU = M2).
- Provides proper address/data-phase tracking, per-master request capture and round-robin fairness.
- Each master sees a plain AHB-Lite slave: it is stalled with HREADY_Mx low while it waits for the bus.
- Sits between el2_swerv_wrapper's ifu/lsu ports and the SoC bus fabric.

---
 rtl/ahb_lite_arb2m_pkg.sv | 29 ++
 rtl/ahb_lite_arb2m_req_hold.sv | 67 ++++++
 rtl/ahb_lite_arb2m.sv | 161 ++++++++++++++++
 tb/tb_ahb_lite_arb2m.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_arb2m_pkg.sv
// Shared AHB-Lite encodings and request record for the two-master arbiter.
package ahb_pkg;

    // Width of the captured address field; the arbiter casts to/from its AW.
    localparam int AHB_AW = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M1   = 2'd1,
        OWN_M2   = 2'd2
    } owner_t;

    typedef struct packed {
        logic [AHB_AW-1:0] addr;
        logic              write;
        logic [2:0]        size;
    } ahb_req_t;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_arb2m_req_hold.sv
// Per-master request holding register: captures one address phase, flags it
// pending until the arbiter grants it, and generates the master's HREADY.
module ahb_req_hold
    import ahb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] haddr_i,
    input  logic [1:0]    htrans_i,
    input  logic          hwrite_i,
    input  logic [2:0]    hsize_i,
    input  logic          own_addr_i,
    input  logic          own_data_i,
    input  logic          hready_i,
    input  logic          grant_i,
    output logic          pend_o,
    output ahb_req_t      req_o,
    output logic          hready_o
);

    logic     pend_q, pend_d;
    ahb_req_t req_q, req_d;
    logic     capture;

    // Stall the master while its request waits or sits in the bus address phase.
    always_comb begin
        hready_o = 1'b1;
        if (pend_q || own_addr_i) begin
            hready_o = 1'b0;
        end else if (own_data_i) begin
            hready_o = hready_i;
        end
    end

    // Latch a new address phase whenever the master sees ready; grant clears it.
    always_comb begin
        capture = hready_o && trans_active(htrans_i);
        pend_d  = pend_q;
        req_d   = req_q;
        if (grant_i) begin
            pend_d = 1'b0;
        end
        if (capture) begin
            pend_d      = 1'b1;
            req_d.addr  = AHB_AW'(haddr_i);
            req_d.write = hwrite_i;
            req_d.size  = hsize_i;
        end
    end

    // Request register; reset drops anything captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            req_q  <= '0;
        end else begin
            pend_q <= pend_d;
            req_q  <= req_d;
        end
    end

    assign pend_o = pend_q;
    assign req_o  = req_q;

endmodule

// File: rtl/ahb_lite_arb2m.sv
// Registered two-master AHB-Lite arbiter (IFU = M1, LSU = M2) onto one slave.
module ahb_lite_arb2m
    import ahb_pkg::*;
#(
    parameter int DW         = 64,
    parameter int AW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] HADDR_M1,
    input  logic [1:0]    HTRANS_M1,
    input  logic          HWRITE_M1,
    input  logic [2:0]    HSIZE_M1,
    input  logic [DW-1:0] HWDATA_M1,
    output logic          HREADY_M1,
    output logic [DW-1:0] HRDATA_M1,
    output logic          HRESP_M1,
    input  logic [AW-1:0] HADDR_M2,
    input  logic [1:0]    HTRANS_M2,
    input  logic          HWRITE_M2,
    input  logic [2:0]    HSIZE_M2,
    input  logic [DW-1:0] HWDATA_M2,
    output logic          HREADY_M2,
    output logic [DW-1:0] HRDATA_M2,
    output logic          HRESP_M2,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    input  logic [DW-1:0] HRDATA,
    input  logic          HRESP,
    output logic [1:0]    HMASTER
);

    owner_t        aowner_q, aowner_d;
    owner_t        downer_q, downer_d;
    owner_t        last_q, last_d;
    logic [AW-1:0] haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic          pend1, pend2, grant1, grant2;
    ahb_req_t      req1, req2;

    ahb_req_hold #(.AW(AW)) u_hold_m1 (
        .clk        (HCLK),
        .rst        (HRESET),
        .haddr_i    (HADDR_M1),
        .htrans_i   (HTRANS_M1),
        .hwrite_i   (HWRITE_M1),
        .hsize_i    (HSIZE_M1),
        .own_addr_i (aowner_q == OWN_M1),
        .own_data_i (downer_q == OWN_M1),
        .hready_i   (HREADY),
        .grant_i    (grant1),
        .pend_o     (pend1),
        .req_o      (req1),
        .hready_o   (HREADY_M1)
    );

    ahb_req_hold #(.AW(AW)) u_hold_m2 (
        .clk        (HCLK),
        .rst        (HRESET),
        .haddr_i    (HADDR_M2),
        .htrans_i   (HTRANS_M2),
        .hwrite_i   (HWRITE_M2),
        .hsize_i    (HSIZE_M2),
        .own_addr_i (aowner_q == OWN_M2),
        .own_data_i (downer_q == OWN_M2),
        .hready_i   (HREADY),
        .grant_i    (grant2),
        .pend_o     (pend2),
        .req_o      (req2),
        .hready_o   (HREADY_M2)
    );

    // Advance the pipeline on slave ready: pick a winner and load the address phase.
    always_comb begin
        aowner_d = aowner_q;
        downer_d = downer_q;
        last_d   = last_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        grant1   = 1'b0;
        grant2   = 1'b0;
        if (HREADY) begin
            downer_d = aowner_q;
            // M1 wins when alone, under fixed priority, or when M2 won last time.
            if (pend1 && (!pend2 || (FIXED_PRIO != 0) || (last_q == OWN_M2))) begin
                grant1 = 1'b1;
            end else if (pend2) begin
                grant2 = 1'b1;
            end
            if (grant1) begin
                haddr_d  = AW'(req1.addr);
                hwrite_d = req1.write;
                hsize_d  = req1.size;
                htrans_d = HTRANS_NONSEQ;
                aowner_d = OWN_M1;
                last_d   = OWN_M1;
            end else if (grant2) begin
                haddr_d  = AW'(req2.addr);
                hwrite_d = req2.write;
                hsize_d  = req2.size;
                htrans_d = HTRANS_NONSEQ;
                aowner_d = OWN_M2;
                last_d   = OWN_M2;
            end else begin
                htrans_d = HTRANS_IDLE;
                aowner_d = OWN_NONE;
            end
        end
    end

    // Owner and slave-side address-phase registers; last starts at M2 so M1 wins the first tie.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            aowner_q <= OWN_NONE;
            downer_q <= OWN_NONE;
            last_q   <= OWN_M2;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
        end else begin
            aowner_q <= aowner_d;
            downer_q <= downer_d;
            last_q   <= last_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
        end
    end

    // Write data follows the data-phase owner; zero when nobody owns it.
    always_comb begin
        HWDATA = '0;
        if (downer_q == OWN_M1) begin
            HWDATA = HWDATA_M1;
        end else if (downer_q == OWN_M2) begin
            HWDATA = HWDATA_M2;
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HMASTER   = downer_q;
    assign HRDATA_M1 = HRDATA;
    assign HRDATA_M2 = HRDATA;
    assign HRESP_M1  = (downer_q == OWN_M1) ? HRESP : 1'b0;
    assign HRESP_M2  = (downer_q == OWN_M2) ? HRESP : 1'b0;

endmodule

// File: tb/tb_ahb_lite_arb2m.sv
// Directed bench for ahb_lite_arb2m: a round-robin instance and a fixed-priority
// instance share every input; the slave side is driven directly by the tasks.
module tb_ahb_lite_arb2m;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] HADDR_M1, HADDR_M2;
    logic [1:0]  HTRANS_M1, HTRANS_M2;
    logic        HWRITE_M1, HWRITE_M2;
    logic [2:0]  HSIZE_M1, HSIZE_M2;
    logic [63:0] HWDATA_M1, HWDATA_M2;
    logic        HREADY;
    logic [63:0] HRDATA;
    logic        HRESP;

    logic        HREADY_M1, HREADY_M2, HRESP_M1, HRESP_M2, HWRITE;
    logic [63:0] HRDATA_M1, HRDATA_M2, HWDATA;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS, HMASTER;
    logic [2:0]  HSIZE;

    logic        HREADY_M1_f, HREADY_M2_f, HRESP_M1_f, HRESP_M2_f, HWRITE_f;
    logic [63:0] HRDATA_M1_f, HRDATA_M2_f, HWDATA_f;
    logic [31:0] HADDR_f;
    logic [1:0]  HTRANS_f, HMASTER_f;
    logic [2:0]  HSIZE_f;

    int total = 0;
    int bad   = 0;

    ahb_lite_arb2m #(.DW(64), .AW(32), .FIXED_PRIO(0)) dut_rr (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1), .HSIZE_M1(HSIZE_M1),
        .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1), .HRDATA_M1(HRDATA_M1), .HRESP_M1(HRESP_M1),
        .HADDR_M2(HADDR_M2), .HTRANS_M2(HTRANS_M2), .HWRITE_M2(HWRITE_M2), .HSIZE_M2(HSIZE_M2),
        .HWDATA_M2(HWDATA_M2), .HREADY_M2(HREADY_M2), .HRDATA_M2(HRDATA_M2), .HRESP_M2(HRESP_M2),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .HMASTER(HMASTER)
    );

    ahb_lite_arb2m #(.DW(64), .AW(32), .FIXED_PRIO(1)) dut_fp (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1), .HSIZE_M1(HSIZE_M1),
        .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1_f), .HRDATA_M1(HRDATA_M1_f), .HRESP_M1(HRESP_M1_f),
        .HADDR_M2(HADDR_M2), .HTRANS_M2(HTRANS_M2), .HWRITE_M2(HWRITE_M2), .HSIZE_M2(HSIZE_M2),
        .HWDATA_M2(HWDATA_M2), .HREADY_M2(HREADY_M2_f), .HRDATA_M2(HRDATA_M2_f), .HRESP_M2(HRESP_M2_f),
        .HADDR(HADDR_f), .HTRANS(HTRANS_f), .HWRITE(HWRITE_f), .HSIZE(HSIZE_f), .HWDATA(HWDATA_f),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .HMASTER(HMASTER_f)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_masters();
        HTRANS_M1 = 2'b00;
        HTRANS_M2 = 2'b00;
    endtask

    task automatic do_reset();
        idle_masters();
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        HADDR_M1 = '0; HADDR_M2 = '0; HWRITE_M1 = 0; HWRITE_M2 = 0;
        HSIZE_M1 = '0; HSIZE_M2 = '0; HWDATA_M1 = '0; HWDATA_M2 = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        idle_masters();
        HRESET = 1'b0;
        #1 HRESET = 1'b1;
        #1;
        total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL reset_htrans got=%h exp=0", HTRANS); end
        total++; if (HADDR !== 32'h0) begin bad++; $display("FAIL reset_haddr got=%h exp=0", HADDR); end
        total++; if (HWRITE !== 1'b0 || HSIZE !== 3'd0) begin bad++; $display("FAIL reset_ctrl got=%b/%h exp=0/0", HWRITE, HSIZE); end
        total++; if (HMASTER !== 2'd0 || HWDATA !== 64'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", HMASTER, HWDATA); end
        total++; if (HREADY_M1 !== 1'b1 || HREADY_M2 !== 1'b1) begin bad++; $display("FAIL reset_hready got=%b%b exp=11", HREADY_M1, HREADY_M2); end
        total++; if (HRESP_M1 !== 1'b0 || HRESP_M2 !== 1'b0) begin bad++; $display("FAIL reset_hresp got=%b%b exp=00", HRESP_M1, HRESP_M2); end
    endtask

    task automatic test_single();
        do_reset();
        HADDR_M1 = 32'h0000_1000; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'd3; HTRANS_M1 = 2'b10;
        total++; if (HREADY_M1 !== 1'b1) begin bad++; $display("FAIL single_accept got=%b exp=1", HREADY_M1); end
        tick(); HTRANS_M1 = 2'b00;
        total++; if (HREADY_M1 !== 1'b0 || HTRANS !== 2'b00) begin bad++; $display("FAIL single_wait got=%b/%h exp=0/0", HREADY_M1, HTRANS); end
        tick();
        total++; if (HTRANS !== 2'b10 || HADDR !== 32'h1000) begin bad++; $display("FAIL single_addr got=%h/%h exp=2/1000", HTRANS, HADDR); end
        total++; if (HSIZE !== 3'd3 || HWRITE !== 1'b0 || HMASTER !== 2'd0) begin bad++; $display("FAIL single_ctrl got=%h/%b/%h exp=3/0/0", HSIZE, HWRITE, HMASTER); end
        HRDATA = 64'hDEADBEEF_CAFEF00D;
        tick();
        total++; if (HMASTER !== 2'd1 || HREADY_M1 !== 1'b1) begin bad++; $display("FAIL single_data got=%h/%b exp=1/1", HMASTER, HREADY_M1); end
        total++; if (HRDATA_M1 !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeefcafef00d", HRDATA_M1); end
        total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL single_idle got=%h exp=0", HTRANS); end
        tick();
        total++; if (HMASTER !== 2'd0) begin bad++; $display("FAIL single_done got=%h exp=0", HMASTER); end
    endtask

    task automatic test_both();
        do_reset();
        HADDR_M1 = 32'h100; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'd2; HTRANS_M1 = 2'b10;
        HADDR_M2 = 32'h200; HWRITE_M2 = 1'b1; HSIZE_M2 = 3'd2; HTRANS_M2 = 2'b10;
        HWDATA_M2 = 64'h55;
        tick(); idle_masters();
        total++; if (HREADY_M1 !== 1'b0 || HREADY_M2 !== 1'b0) begin bad++; $display("FAIL both_stall got=%b%b exp=00", HREADY_M1, HREADY_M2); end
        tick();
        total++; if (HTRANS !== 2'b10 || HADDR !== 32'h100 || HWRITE !== 1'b0) begin bad++; $display("FAIL both_first got=%h/%h/%b exp=2/100/0", HTRANS, HADDR, HWRITE); end
        total++; if (HREADY_M2 !== 1'b0) begin bad++; $display("FAIL both_m2_wait1 got=%b exp=0", HREADY_M2); end
        tick();
        total++; if (HADDR !== 32'h200 || HWRITE !== 1'b1 || HMASTER !== 2'd1) begin bad++; $display("FAIL both_second got=%h/%b/%h exp=200/1/1", HADDR, HWRITE, HMASTER); end
        total++; if (HREADY_M1 !== 1'b1 || HREADY_M2 !== 1'b0) begin bad++; $display("FAIL both_ready got=%b%b exp=10", HREADY_M1, HREADY_M2); end
        tick();
        total++; if (HMASTER !== 2'd2 || HWDATA !== 64'h55 || HREADY_M2 !== 1'b1) begin bad++; $display("FAIL both_wdata got=%h/%h/%b exp=2/55/1", HMASTER, HWDATA, HREADY_M2); end
        tick();
        total++; if (HMASTER !== 2'd0 || HWDATA !== 64'h0) begin bad++; $display("FAIL both_done got=%h/%h exp=0/0", HMASTER, HWDATA); end
    endtask

    task automatic test_tie_prio();
        do_reset();
        HADDR_M1 = 32'h100; HWRITE_M1 = 1'b0; HTRANS_M1 = 2'b10;
        tick(); idle_masters();
        repeat (3) tick();
        HADDR_M2 = 32'h200; HWRITE_M2 = 1'b0; HTRANS_M1 = 2'b10; HTRANS_M2 = 2'b10;
        tick(); idle_masters();
        tick();
        total++; if (HADDR !== 32'h200) begin bad++; $display("FAIL tie_rr_first got=%h exp=200", HADDR); end
        total++; if (HADDR_f !== 32'h100) begin bad++; $display("FAIL tie_fp_first got=%h exp=100", HADDR_f); end
        tick();
        total++; if (HADDR !== 32'h100) begin bad++; $display("FAIL tie_rr_second got=%h exp=100", HADDR); end
        total++; if (HADDR_f !== 32'h200) begin bad++; $display("FAIL tie_fp_second got=%h exp=200", HADDR_f); end
    endtask

    task automatic test_round_robin();
        int n, nf;
        logic [31:0] exp_a;
        n = 0; nf = 0;
        do_reset();
        HADDR_M1 = 32'h100; HADDR_M2 = 32'h200; HWRITE_M1 = 1'b0; HWRITE_M2 = 1'b0;
        HTRANS_M1 = 2'b10; HTRANS_M2 = 2'b10;
        for (int c = 0; c < 40 && (n < 8 || nf < 8); c++) begin
            tick();
            if (HTRANS == 2'b10 && n < 8) begin
                exp_a = (n % 2 == 0) ? 32'h100 : 32'h200;
                total++; if (HADDR !== exp_a) begin bad++; $display("FAIL rr_seq%0d got=%h exp=%h", n, HADDR, exp_a); end
                n++;
            end
            if (HTRANS_f == 2'b10 && nf < 8) begin
                exp_a = (nf % 2 == 0) ? 32'h100 : 32'h200;
                total++; if (HADDR_f !== exp_a) begin bad++; $display("FAIL fp_seq%0d got=%h exp=%h", nf, HADDR_f, exp_a); end
                nf++;
            end
        end
        total++; if (n != 8 || nf != 8) begin bad++; $display("FAIL rr_count got=%0d/%0d exp=8/8", n, nf); end
        idle_masters();
        repeat (4) tick();
    endtask

    task automatic test_wait_states();
        do_reset();
        HADDR_M2 = 32'h300; HWRITE_M2 = 1'b1; HSIZE_M2 = 3'd2; HWDATA_M2 = 64'hA5A5; HTRANS_M2 = 2'b10;
        tick(); idle_masters();
        tick();
        total++; if (HTRANS !== 2'b10 || HADDR !== 32'h300) begin bad++; $display("FAIL wait_addr got=%h/%h exp=2/300", HTRANS, HADDR); end
        tick();
        HREADY = 1'b0;
        HADDR_M1 = 32'h100; HWRITE_M1 = 1'b0; HTRANS_M1 = 2'b10;
        #1;
        total++; if (HMASTER !== 2'd2 || HWDATA !== 64'hA5A5 || HREADY_M1 !== 1'b1) begin bad++; $display("FAIL wait_start got=%h/%h/%b exp=2/a5a5/1", HMASTER, HWDATA, HREADY_M1); end
        for (int w = 0; w < 3; w++) begin
            tick();
            if (w == 0) idle_masters();
            total++; if (HADDR !== 32'h300 || HTRANS !== 2'b00 || HWDATA !== 64'hA5A5 || HMASTER !== 2'd2) begin
                bad++; $display("FAIL wait_hold%0d got=%h/%h/%h/%h exp=300/0/a5a5/2", w, HADDR, HTRANS, HWDATA, HMASTER);
            end
            total++; if (HREADY_M2 !== 1'b0) begin bad++; $display("FAIL wait_m2_%0d got=%b exp=0", w, HREADY_M2); end
        end
        HREADY = 1'b1;
        #1;
        total++; if (HREADY_M2 !== 1'b1 || HWDATA !== 64'hA5A5) begin bad++; $display("FAIL wait_end got=%b/%h exp=1/a5a5", HREADY_M2, HWDATA); end
        tick();
        total++; if (HTRANS !== 2'b10 || HADDR !== 32'h100 || HWRITE !== 1'b0 || HMASTER !== 2'd0) begin bad++; $display("FAIL wait_m1_issue got=%h/%h/%b/%h exp=2/100/0/0", HTRANS, HADDR, HWRITE, HMASTER); end
    endtask

    task automatic test_error();
        do_reset();
        HADDR_M1 = 32'h400; HWRITE_M1 = 1'b0; HTRANS_M1 = 2'b10;
        tick(); idle_masters();
        tick();
        HADDR_M2 = 32'h500; HWRITE_M2 = 1'b0; HTRANS_M2 = 2'b10;
        tick(); idle_masters();
        HRESP = 1'b1; HREADY = 1'b0;
        #1;
        total++; if (HRESP_M1 !== 1'b1 || HREADY_M1 !== 1'b0) begin bad++; $display("FAIL err_first got=%b/%b exp=1/0", HRESP_M1, HREADY_M1); end
        total++; if (HRESP_M2 !== 1'b0 || HREADY_M2 !== 1'b0) begin bad++; $display("FAIL err_m2_first got=%b/%b exp=0/0", HRESP_M2, HREADY_M2); end
        tick();
        HREADY = 1'b1;
        #1;
        total++; if (HRESP_M1 !== 1'b1 || HREADY_M1 !== 1'b1 || HRESP_M2 !== 1'b0) begin bad++; $display("FAIL err_second got=%b/%b/%b exp=1/1/0", HRESP_M1, HREADY_M1, HRESP_M2); end
        tick();
        HRESP = 1'b0;
        #1;
        total++; if (HTRANS !== 2'b10 || HADDR !== 32'h500 || HMASTER !== 2'd0) begin bad++; $display("FAIL err_m2_issue got=%h/%h/%h exp=2/500/0", HTRANS, HADDR, HMASTER); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        HADDR_M2 = 32'h600; HWRITE_M2 = 1'b1; HSIZE_M2 = 3'd1; HWDATA_M2 = 64'h77; HTRANS_M2 = 2'b10;
        tick(); idle_masters();
        tick();
        HADDR_M1 = 32'h100; HWRITE_M1 = 1'b0; HTRANS_M1 = 2'b10;
        tick(); idle_masters();
        total++; if (HMASTER !== 2'd2 || HREADY_M1 !== 1'b0) begin bad++; $display("FAIL rmid_pre got=%h/%b exp=2/0", HMASTER, HREADY_M1); end
        #2 HRESET = 1'b1;
        #1;
        total++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'd0) begin bad++; $display("FAIL rmid_addr got=%h/%h/%b/%h exp=0/0/0/0", HTRANS, HADDR, HWRITE, HSIZE); end
        total++; if (HMASTER !== 2'd0 || HWDATA !== 64'h0) begin bad++; $display("FAIL rmid_data got=%h/%h exp=0/0", HMASTER, HWDATA); end
        total++; if (HREADY_M1 !== 1'b1 || HREADY_M2 !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b%b exp=11", HREADY_M1, HREADY_M2); end
        tick(); tick();
        HRESET = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (HTRANS !== 2'b00 || HMASTER !== 2'd0) begin bad++; $display("FAIL rmid_stale%0d got=%h/%h exp=0/0", c, HTRANS, HMASTER); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_tie_prio();
        test_round_robin();
        test_wait_states();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
